// File: rtl/health_mon_mc.sv
// rtl/health_mon_mc.sv - multi-channel entropy repetition-count and adaptive-proportion health monitor
// The proportion test is built only when HEALTHMON_APT_EN is defined.
module health_mon_mc #(
  parameter int NCH  = 4,
  parameter int CNTW = 8,
  parameter int WINW = 9
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NCH-1:0]  digi_data_out,
  input  logic [NCH-1:0]  digi_data_vld,
  input  logic            healthtest_en,
  input  logic [CNTW-1:0] rct_cutoff,
  input  logic [WINW:0]   apt_cutoff,
  input  logic            err_clr,
  output logic [NCH-1:0]  rct_err,
  output logic [NCH-1:0]  apt_err,
  output logic            healthtest_err,
  output logic [7:0]      fail_cnt
);

  localparam int MW = WINW + 1;

  logic [NCH-1:0]           first_q, first_d;
  logic [NCH-1:0]           prev_q, prev_d;
  logic [NCH-1:0][CNTW-1:0] run_q, run_d, run_nxt;
  logic [NCH-1:0]           rct_q, rct_d;
  logic [NCH-1:0]           apt_q, apt_d;
  logic [7:0]               fail_q, fail_d;
  logic [7:0]               rise_cnt;
  logic [8:0]               fail_sum;

  // Repetition-count test: first sample of a run only seeds the reference.
  always_comb begin
    first_d = first_q;
    prev_d  = prev_q;
    run_d   = run_q;
    run_nxt = run_q;
    rct_d   = rct_q;
    for (int i = 0; i < NCH; i++) begin
      if (!healthtest_en || err_clr) begin
        first_d[i] = 1'b1;
        prev_d[i]  = 1'b0;
        run_d[i]   = '0;
        rct_d[i]   = 1'b0;
      end else if (digi_data_vld[i]) begin
        if (first_q[i]) begin
          first_d[i] = 1'b0;
          prev_d[i]  = digi_data_out[i];
          run_d[i]   = CNTW'(1);
        end else begin
          if (digi_data_out[i] == prev_q[i])
            run_nxt[i] = (&run_q[i]) ? run_q[i] : run_q[i] + CNTW'(1);
          else
            run_nxt[i] = CNTW'(1);
          run_d[i]  = run_nxt[i];
          prev_d[i] = digi_data_out[i];
          if (rct_cutoff != '0 && run_nxt[i] >= rct_cutoff)
            rct_d[i] = 1'b1;
        end
      end
    end
  end

`ifdef HEALTHMON_APT_EN
  localparam logic [1:0]    ST_IDLE  = 2'd0;
  localparam logic [1:0]    ST_REF   = 2'd1;
  localparam logic [1:0]    ST_COUNT = 2'd2;
  localparam logic [WINW:0] WIN_LEN  = {1'b1, {WINW{1'b0}}};

  logic [NCH-1:0][1:0]    st_q, st_d;
  logic [NCH-1:0]         ref_q, ref_d;
  logic [NCH-1:0][WINW:0] match_q, match_d, match_nxt;
  logic [NCH-1:0][WINW:0] win_q, win_d, win_nxt;

  always_comb begin
    st_d      = st_q;
    ref_d     = ref_q;
    match_d   = match_q;
    match_nxt = match_q;
    win_d     = win_q;
    win_nxt   = win_q;
    apt_d     = apt_q;
    for (int i = 0; i < NCH; i++) begin
      if (!healthtest_en) begin
        st_d[i]    = ST_IDLE;
        ref_d[i]   = 1'b0;
        match_d[i] = '0;
        win_d[i]   = '0;
        apt_d[i]   = 1'b0;
      end else if (err_clr) begin
        st_d[i]    = ST_REF;
        ref_d[i]   = 1'b0;
        match_d[i] = '0;
        win_d[i]   = '0;
        apt_d[i]   = 1'b0;
      end else begin
        case (st_q[i])
          ST_IDLE, ST_REF: begin
            st_d[i] = ST_REF;
            if (digi_data_vld[i]) begin
              ref_d[i]   = digi_data_out[i];
              match_d[i] = MW'(1);
              win_d[i]   = MW'(1);
              st_d[i]    = ST_COUNT;
            end
          end
          ST_COUNT: begin
            if (digi_data_vld[i]) begin
              win_nxt[i]   = win_q[i] + MW'(1);
              match_nxt[i] = match_q[i] + MW'(digi_data_out[i] == ref_q[i]);
              win_d[i]     = win_nxt[i];
              match_d[i]   = match_nxt[i];
              if (apt_cutoff != '0 && match_nxt[i] > apt_cutoff)
                apt_d[i] = 1'b1;
              // The window's last sample is scored before the state returns to REF.
              if (win_nxt[i] == WIN_LEN)
                st_d[i] = ST_REF;
            end
          end
          default: st_d[i] = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q    <= {NCH{ST_IDLE}};
      ref_q   <= '0;
      match_q <= '0;
      win_q   <= '0;
    end else begin
      st_q    <= st_d;
      ref_q   <= ref_d;
      match_q <= match_d;
      win_q   <= win_d;
    end
  end
`else
  logic unused_apt_cutoff;
  assign unused_apt_cutoff = ^apt_cutoff;
  assign apt_d = '0;
`endif

  always_comb begin
    rise_cnt = '0;
    for (int i = 0; i < NCH; i++) begin
      rise_cnt = rise_cnt + 8'(rct_d[i] & ~rct_q[i]) + 8'(apt_d[i] & ~apt_q[i]);
    end
    fail_sum = {1'b0, fail_q} + {1'b0, rise_cnt};
    if (!healthtest_en)
      fail_d = fail_q;
    else if (err_clr)
      fail_d = '0;
    else
      fail_d = fail_sum[8] ? 8'hFF : fail_sum[7:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      first_q <= '1;
      prev_q  <= '0;
      run_q   <= '0;
      rct_q   <= '0;
      apt_q   <= '0;
      fail_q  <= '0;
    end else begin
      first_q <= first_d;
      prev_q  <= prev_d;
      run_q   <= run_d;
      rct_q   <= rct_d;
      apt_q   <= apt_d;
      fail_q  <= fail_d;
    end
  end

  assign rct_err        = rct_q;
  assign apt_err        = apt_q;
  assign healthtest_err = (|rct_q) | (|apt_q);
  assign fail_cnt       = fail_q;

endmodule

// File: tb/tb_health_mon_mc.sv
// tb/tb_health_mon_mc.sv - directed self-checking bench for health_mon_mc
// Proportion expectations follow HEALTHMON_APT_EN as defined for the build.
module tb_health_mon_mc;

`ifdef HEALTHMON_APT_EN
  localparam bit APT = 1'b1;
`else
  localparam bit APT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [3:0] dat = '0;
  logic [3:0] vld = '0;
  logic       en = 1'b0;
  logic [7:0] rct_cut = 8'd5;
  logic [9:0] apt_cut = 10'd300;
  logic       clr = 1'b0;
  logic [3:0] rct_err;
  logic [3:0] apt_err;
  logic       ht_err;
  logic [7:0] fail_cnt;
  int checks = 0;
  int errors = 0;

  health_mon_mc #(.NCH(4), .CNTW(8), .WINW(9)) dut (
    .clk(clk), .rstn(rstn),
    .digi_data_out(dat), .digi_data_vld(vld),
    .healthtest_en(en), .rct_cutoff(rct_cut), .apt_cutoff(apt_cut),
    .err_clr(clr),
    .rct_err(rct_err), .apt_err(apt_err),
    .healthtest_err(ht_err), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic sample(input logic [3:0] v, input logic [3:0] d);
    @(negedge clk);
    vld = v;
    dat = d;
    @(posedge clk);
    #1;
    vld = '0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (rct_err !== 4'b0000) begin errors++; $display("FAIL reset_rct got %b want 0000", rct_err); end
    checks++; if (apt_err !== 4'b0000) begin errors++; $display("FAIL reset_apt got %b want 0000", apt_err); end
    checks++; if (ht_err !== 1'b0) begin errors++; $display("FAIL reset_ht got %b want 0", ht_err); end
    checks++; if (fail_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", fail_cnt); end
    @(negedge clk);
    rstn = 1'b1;
    en = 1'b1;
  endtask

  task automatic test_rct();
    for (int k = 0; k < 6; k++) begin
      sample(4'b0001, 4'b0001);
      if (k == 3) begin
        checks++; if (rct_err !== 4'b0000) begin errors++; $display("FAIL rct_before got %b want 0000", rct_err); end
      end
      if (k == 4) begin
        checks++; if (rct_err !== 4'b0001) begin errors++; $display("FAIL rct_5th got %b want 0001", rct_err); end
        checks++; if (fail_cnt !== 8'd1) begin errors++; $display("FAIL rct_cnt got %0d want 1", fail_cnt); end
        checks++; if (ht_err !== 1'b1) begin errors++; $display("FAIL rct_ht got %b want 1", ht_err); end
      end
    end
    checks++; if (fail_cnt !== 8'd1) begin errors++; $display("FAIL rct_sticky_cnt got %0d want 1", fail_cnt); end
    pulse_clr();
    checks++; if (rct_err !== 4'b0000 || fail_cnt !== 8'd0) begin errors++; $display("FAIL rct_clr got %b/%0d want 0000/0", rct_err, fail_cnt); end
  endtask

  task automatic test_alternating();
    for (int k = 0; k < 1000; k++) sample(4'b0010, (k % 2 == 1) ? 4'b0010 : 4'b0000);
    checks++; if (rct_err !== 4'b0000) begin errors++; $display("FAIL alt_rct got %b want 0000", rct_err); end
    checks++; if (apt_err !== 4'b0000) begin errors++; $display("FAIL alt_apt got %b want 0000", apt_err); end
    checks++; if (fail_cnt !== 8'd0) begin errors++; $display("FAIL alt_cnt got %0d want 0", fail_cnt); end
  endtask

  task automatic test_apt();
    logic [3:0] exp_apt;
    exp_apt = APT ? 4'b0100 : 4'b0000;
    rct_cut = 8'd0;
    apt_cut = 10'd300;
    pulse_clr();
    for (int k = 0; k < 512; k++) begin
      sample(4'b0100, (k < 301) ? 4'b0100 : 4'b0000);
      if (k == 299) begin
        checks++; if (apt_err !== 4'b0000) begin errors++; $display("FAIL apt_300 got %b want 0000", apt_err); end
      end
      if (k == 300) begin
        checks++; if (apt_err !== exp_apt) begin errors++; $display("FAIL apt_301 got %b want %b", apt_err, exp_apt); end
        checks++; if (fail_cnt !== 8'(APT)) begin errors++; $display("FAIL apt_cnt got %0d want %0d", fail_cnt, APT); end
      end
    end
    checks++; if (rct_err !== 4'b0000 || apt_err !== exp_apt) begin errors++; $display("FAIL apt_end got %b/%b want 0000/%b", rct_err, apt_err, exp_apt); end
    pulse_clr();
    for (int k = 0; k < 512; k++) sample(4'b0100, (k < 300) ? 4'b0100 : 4'b0000);
    checks++; if (apt_err !== 4'b0000) begin errors++; $display("FAIL apt_only300 got %b want 0000", apt_err); end
    checks++; if (fail_cnt !== 8'd0) begin errors++; $display("FAIL apt_only300_cnt got %0d want 0", fail_cnt); end
  endtask

  task automatic test_same_edge();
    rct_cut = 8'd5;
    pulse_clr();
    for (int k = 0; k < 5; k++) sample(4'b1001, 4'b1001);
    checks++; if (rct_err !== 4'b1001) begin errors++; $display("FAIL dual_rct got %b want 1001", rct_err); end
    checks++; if (fail_cnt !== 8'd2) begin errors++; $display("FAIL dual_cnt got %0d want 2", fail_cnt); end
    pulse_clr();
    checks++; if (rct_err !== 4'b0000 || ht_err !== 1'b0 || fail_cnt !== 8'd0) begin errors++; $display("FAIL dual_clr got %b/%b/%0d want 0000/0/0", rct_err, ht_err, fail_cnt); end
  endtask

  task automatic test_enable();
    for (int k = 0; k < 3; k++) sample(4'b0001, 4'b0001);
    @(negedge clk);
    en = 1'b0;
    sample(4'b0001, 4'b0001);
    sample(4'b0001, 4'b0001);
    @(negedge clk);
    en = 1'b1;
    for (int k = 0; k < 4; k++) sample(4'b0001, 4'b0001);
    checks++; if (rct_err !== 4'b0000 || apt_err !== 4'b0000) begin errors++; $display("FAIL en_restart got %b/%b want 0000/0000", rct_err, apt_err); end
    sample(4'b0001, 4'b0001);
    checks++; if (rct_err !== 4'b0001 || fail_cnt !== 8'd1) begin errors++; $display("FAIL en_5th got %b/%0d want 0001/1", rct_err, fail_cnt); end
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (rct_err !== 4'b0000 || fail_cnt !== 8'd1) begin errors++; $display("FAIL en_low got %b/%0d want 0000/1", rct_err, fail_cnt); end
    @(negedge clk);
    en = 1'b1;
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 5; k++) sample(4'b0001, 4'b0001);
    checks++; if (rct_err !== 4'b0001 || fail_cnt !== 8'd2) begin errors++; $display("FAIL pre_rst got %b/%0d want 0001/2", rct_err, fail_cnt); end
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    checks++; if (rct_err !== 4'b0000 || apt_err !== 4'b0000 || ht_err !== 1'b0 || fail_cnt !== 8'd0) begin
      errors++; $display("FAIL async_rst got %b/%b/%b/%0d want 0000/0000/0/0", rct_err, apt_err, ht_err, fail_cnt);
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) sample(4'b0001, 4'b0001);
    checks++; if (rct_err !== 4'b0000) begin errors++; $display("FAIL post_rst_4 got %b want 0000", rct_err); end
    sample(4'b0001, 4'b0001);
    checks++; if (rct_err !== 4'b0001 || fail_cnt !== 8'd1) begin errors++; $display("FAIL post_rst_5 got %b/%0d want 0001/1", rct_err, fail_cnt); end
  endtask

  initial begin
    test_reset();
    test_rct();
    test_alternating();
    test_apt();
    test_same_edge();
    test_enable();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
